hazard_sequencer: RTL

Central stall/flush controller for the 5-stage RV32I pipeline. It takes branch resolution from EX (beq/bne `branch_taken`), load-use dependencies between ID and EX, and a data-memory busy signal. It drives every PC and pipeline-register write enable, flush and redirect select. A small FSM extends the branch flush over the instruction-memory latency window, so wrong-path fetches still in flight are killed as well.

---
 rtl/hazard_sequencer_pkg.sv | 26 ++
 rtl/hazard_sequencer_if.sv | 55 +++++
 rtl/hazard_sequencer_lu.sv | 20 ++
 rtl/hazard_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard sequencer and its neighbours
// (the branch unit uses the funct3 encodings as well).
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        BR_FLUSH = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [2:0] FUNCT3_BEQ = 3'b000;
    localparam logic [2:0] FUNCT3_BNE = 3'b001;

    typedef struct packed {
        logic pc_we;
        logic pc_sel_branch;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic busy_flush;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bundle: pipeline status in, stall/flush/redirect controls out.
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_sequencer_if;
    logic       ex_branch;
    logic       ex_branch_taken;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       mem_busy;

    logic       pc_we;
    logic       pc_sel_branch;
    logic       if_id_we;
    logic       id_ex_we;
    logic       ex_mem_we;
    logic       mem_wb_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       busy_flush;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] freeze_cnt;

    modport master (
        output ex_branch, ex_branch_taken, ex_mem_read, ex_rd, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, mem_busy,
        input  pc_we, pc_sel_branch, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, busy_flush, stall_cnt, flush_cnt, freeze_cnt
    );
    modport slave (
        input  ex_branch, ex_branch_taken, ex_mem_read, ex_rd, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, mem_busy,
        output pc_we, pc_sel_branch, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, busy_flush, stall_cnt, flush_cnt, freeze_cnt
    );
`else
    modport master (
        output ex_branch, ex_branch_taken, ex_mem_read, ex_rd, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, mem_busy,
        input  pc_we, pc_sel_branch, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, busy_flush
    );
    modport slave (
        input  ex_branch, ex_branch_taken, ex_mem_read, ex_rd, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, mem_busy,
        output pc_we, pc_sel_branch, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, busy_flush
    );
`endif
endinterface

// File: rtl/hazard_sequencer_lu.sv
// Combinational load-use compare between the load in EX and the sources read in ID.
// Also reused standalone by the forwarding unit tests.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    output logic       lu_o
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign lu_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) &&
                  ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                   (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush/redirect controller for the 5-stage RV32I pipeline.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int IMEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    hazard_sequencer_if.slave  hz
);

    localparam logic [1:0] LAT_C = 2'(IMEM_LAT);

    hz_state_t  state_q, state_d;
    logic [1:0] ctr_q, ctr_d;
    logic       lu;
    logic       redir;
    hz_ctrl_t   ctrl;

    load_use_detect u_lu (
        .ex_mem_read_i (hz.ex_mem_read),
        .ex_rd_i       (hz.ex_rd),
        .id_rs1_i      (hz.id_rs1),
        .id_rs2_i      (hz.id_rs2),
        .id_use_rs1_i  (hz.id_use_rs1),
        .id_use_rs2_i  (hz.id_use_rs2),
        .lu_o          (lu)
    );

    // Bubbles carry branch=0, so a taken branch in EX is always a real one
    assign redir = hz.ex_branch && hz.ex_branch_taken;

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        ctr_d   = ctr_q;
        if (rst) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            state_d          = RUN;
            ctr_d            = 2'd0;
        end else if (hz.mem_busy) begin
            ctrl.busy_flush = (state_q == BR_FLUSH);
        end else if (redir) begin
            ctrl          = '1;
            ctrl.busy_flush = (state_q == BR_FLUSH);
            if (IMEM_LAT > 0) begin
                state_d = BR_FLUSH;
                ctr_d   = LAT_C;
            end else begin
                state_d = RUN;
                ctr_d   = 2'd0;
            end
        end else if (state_q == BR_FLUSH) begin
            ctrl.pc_we       = 1'b1;
            ctrl.if_id_we    = 1'b1;
            ctrl.id_ex_we    = 1'b1;
            ctrl.ex_mem_we   = 1'b1;
            ctrl.mem_wb_we   = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.busy_flush  = 1'b1;
            // Counter value 1 marks the last wrong-path fetch still in flight
            if (ctr_q <= 2'd1) begin
                state_d = RUN;
                ctr_d   = 2'd0;
            end else begin
                ctr_d = ctr_q - 2'd1;
            end
        end else if (lu) begin
            ctrl.id_ex_we    = 1'b1;
            ctrl.ex_mem_we   = 1'b1;
            ctrl.mem_wb_we   = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else begin
            ctrl.pc_we     = 1'b1;
            ctrl.if_id_we  = 1'b1;
            ctrl.id_ex_we  = 1'b1;
            ctrl.ex_mem_we = 1'b1;
            ctrl.mem_wb_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ctr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    assign hz.pc_we         = ctrl.pc_we;
    assign hz.pc_sel_branch = ctrl.pc_sel_branch;
    assign hz.if_id_we      = ctrl.if_id_we;
    assign hz.id_ex_we      = ctrl.id_ex_we;
    assign hz.ex_mem_we     = ctrl.ex_mem_we;
    assign hz.mem_wb_we     = ctrl.mem_wb_we;
    assign hz.if_id_flush   = ctrl.if_id_flush;
    assign hz.id_ex_flush   = ctrl.id_ex_flush;
    assign hz.busy_flush    = ctrl.busy_flush;

`ifdef HAZARD_PERF_EN
    logic        stall_c, redir_c, freeze_c;
    logic [31:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    assign freeze_c = !rst && hz.mem_busy;
    assign redir_c  = !rst && !hz.mem_busy && redir;
    assign stall_c  = !rst && !hz.mem_busy && !redir && (state_q == RUN) && lu;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (stall_c)  stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (redir_c)  flush_cnt_q  <= flush_cnt_q + 32'd1;
            if (freeze_c) freeze_cnt_q <= freeze_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;
    assign hz.freeze_cnt = freeze_cnt_q;
`endif

endmodule
